// File: rtl/simplez_core.sv
// Simplez CPU core: accumulator datapath plus control FSM, all memory and I/O
// through a single request/acknowledge bus. Optional hardware single-step is
// enabled by defining SIMPLEZ_STEP_EN (adds the step input and an IDLE state).
module simplez_core #(
  parameter int unsigned DW = 12,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] bus_addr,
  output logic          bus_rd,
  output logic          bus_we,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  input  logic          tick,
  output logic [DW-1:0] acc,
  output logic [AW-1:0] pc,
  output logic          flag_z,
  output logic          stop
`ifdef SIMPLEZ_STEP_EN
  ,
  input  logic          step
`endif
);

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_ST  = 3'd0;
  localparam logic [OPW-1:0] OP_LD  = 3'd1;
  localparam logic [OPW-1:0] OP_ADD = 3'd2;
  localparam logic [OPW-1:0] OP_BR  = 3'd3;
  localparam logic [OPW-1:0] OP_BZ  = 3'd4;
  localparam logic [OPW-1:0] OP_CLR = 3'd5;
  localparam logic [OPW-1:0] OP_DEC = 3'd6;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_WAITT  = 3'd3,
    S_END    = 3'd4,
    S_HALTED = 3'd5,
    S_IDLE   = 3'd6
  } state_t;

`ifdef SIMPLEZ_STEP_EN
  localparam state_t S_RESET = S_IDLE;
  localparam state_t S_NEXT  = S_IDLE;
`else
  localparam state_t S_RESET = S_FETCH;
  localparam state_t S_NEXT  = S_FETCH;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_acc;
  logic [AW-1:0]   r_pc;
  logic [DW-1:0]   r_ri;
  logic            r_flag_z;
  logic            r_stop;

  logic [OPW-1:0]  w_op;
  logic            w_ext_wait;
  logic [AW-1:0]   w_cd;
  logic            w_acc_we;
  logic [DW-1:0]   w_acc_nxt;

  // Instruction field decode; the extended-opcode LSB separates HALT from WAIT
  assign w_op       = r_ri[DW-1 -: OPW];
  assign w_ext_wait = r_ri[DW-4];
  assign w_cd       = r_ri[AW-1:0];

  assign bus_wdata = r_acc;
  assign acc       = r_acc;
  assign pc        = r_pc;
  assign flag_z    = r_flag_z;
  assign stop      = r_stop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; taken branches also return to IDLE so a step runs one instruction
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus_ack) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        case (w_op)
          OP_ST, OP_LD, OP_ADD: w_state_nxt = S_MEM;
          OP_BR:                w_state_nxt = S_NEXT;
          OP_BZ:                w_state_nxt = r_flag_z ? S_NEXT : S_END;
          OP_CLR, OP_DEC:       w_state_nxt = S_END;
          default:              w_state_nxt = w_ext_wait ? S_WAITT : S_HALTED;
        endcase
      end
      S_MEM: begin
        if (bus_ack) w_state_nxt = S_END;
      end
      S_WAITT: begin
        if (tick) w_state_nxt = S_END;
      end
      S_END: begin
        w_state_nxt = S_NEXT;
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
`ifdef SIMPLEZ_STEP_EN
      S_IDLE: begin
        if (step) w_state_nxt = S_FETCH;
      end
`endif
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase
  end

  // Bus request decode from state; reset forces requests low immediately
  always_comb begin
    bus_rd   = 1'b0;
    bus_we   = 1'b0;
    bus_addr = r_pc;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          bus_rd = 1'b1;
        end
        S_MEM: begin
          bus_addr = w_cd;
          if (w_op == OP_ST) bus_we = 1'b1;
          else               bus_rd = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Accumulator next value for LD, ADD, CLR and DEC (modulo 2^DW)
  always_comb begin
    w_acc_we  = 1'b0;
    w_acc_nxt = r_acc;
    case (r_state)
      S_EXEC: begin
        if (w_op == OP_CLR) begin
          w_acc_we  = 1'b1;
          w_acc_nxt = '0;
        end else if (w_op == OP_DEC) begin
          w_acc_we  = 1'b1;
          w_acc_nxt = r_acc - DW'(1);
        end
      end
      S_MEM: begin
        if (bus_ack && (w_op == OP_LD)) begin
          w_acc_we  = 1'b1;
          w_acc_nxt = bus_rdata;
        end else if (bus_ack && (w_op == OP_ADD)) begin
          w_acc_we  = 1'b1;
          w_acc_nxt = r_acc + bus_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers: instruction, accumulator, zero flag, pc, stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_pc     <= '0;
      r_ri     <= '0;
      r_flag_z <= 1'b0;
      r_stop   <= 1'b0;
    end else begin
      if (w_acc_we) begin
        r_acc    <= w_acc_nxt;
        r_flag_z <= (w_acc_nxt == '0);
      end
      case (r_state)
        S_FETCH: begin
          if (bus_ack) r_ri <= bus_rdata;
        end
        S_EXEC: begin
          if (w_op == OP_BR) begin
            r_pc <= w_cd;
          end else if ((w_op == OP_BZ) && r_flag_z) begin
            r_pc <= w_cd;
          end else if ((w_op == 3'd7) && !w_ext_wait) begin
            r_stop <= 1'b1;
          end
        end
        S_END: begin
          r_pc <= r_pc + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_core.sv
// Scoreboard bench for simplez_core: a bus memory model answers requests,
// expected bus transactions are queued by the stimulus and checked by a monitor.
module tb_simplez_core;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 9;
  localparam int unsigned MW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] bus_addr;
  logic          bus_rd;
  logic          bus_we;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          tick = 1'b0;
  logic [DW-1:0] acc;
  logic [AW-1:0] pc;
  logic          flag_z;
  logic          stop;
`ifdef SIMPLEZ_STEP_EN
  logic          step = 1'b0;
`endif

  simplez_core #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .tick      (tick),
    .acc       (acc),
    .pc        (pc),
    .flag_z    (flag_z),
    .stop      (stop)
`ifdef SIMPLEZ_STEP_EN
    ,
    .step      (step)
`endif
  );

  always #5 clk = ~clk;

  // Memory model with a programmable number of wait cycles per request
  logic [DW-1:0] mem [0:MW-1];
  int unsigned   ack_delay = 0;
  int unsigned   wcnt = 0;

  assign bus_ack   = (wcnt == ack_delay);
  assign bus_rdata = mem[bus_addr];

  always @(posedge clk) begin
    if (!(bus_rd || bus_we) || bus_ack) wcnt <= 0;
    else                                wcnt <= wcnt + 1;
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic          chk;
    logic [DW-1:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, chk: 1'b0, data: '0});
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, chk: 1'b1, data: d});
  endtask

  // Monitor: exclusivity, hold-while-pending, and completed transactions vs. queue
  logic        prev_hold = 1'b0;
  logic [31:0] snap = '0;
  always @(negedge clk) begin
    txn_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      check("rd_we_exclusive", 32'(bus_rd & bus_we), 32'd0);
      if (prev_hold)
        check("bus_hold", 32'({bus_rd, bus_we, bus_addr, bus_wdata}), snap);
      if ((bus_rd || bus_we) && bus_ack) begin
        if (exp_q.size() == 0) begin
          check("txn_unexpected", 32'(bus_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("txn_we", 32'(bus_we), 32'(e.we));
          check("txn_addr", 32'(bus_addr), 32'(e.addr));
          if (e.chk) check("txn_wdata", 32'(bus_wdata), 32'(e.data));
        end
      end
      prev_hold = (bus_rd || bus_we) && !bus_ack;
      snap      = 32'({bus_rd, bus_we, bus_addr, bus_wdata});
    end
  end

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_test(input int unsigned dly);
    rst = 1'b1;
    tick = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(MW); i++) mem[i] = '0;
    ack_delay = dly;
    cycles(2);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic end_test(input string name);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic wait_stop(input int bound, output int n);
    n = 0;
    while (!stop && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
`ifdef SIMPLEZ_STEP_EN
    // Single-step: BR 511 then CLR at 511, one instruction per pulse, pc wraps
    begin_test(0);
    mem[0]   = 12'h7FF;
    mem[511] = 12'hA00;
    step = 1'b0;
    release_rst();
    cycles(5);
    check("step_idle_pc", 32'(pc), 32'd0);
    exp_rd(9'd0);
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(5);
    check("step1_pc", 32'(pc), 32'd511);
    check("step1_one_fetch", 32'(exp_q.size()), 32'd0);
    exp_rd(9'd511);
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(6);
    check("step2_pc_wrap", 32'(pc), 32'd0);
    check("step2_flag_z", 32'(flag_z), 32'd1);
    end_test("step");
`else
    // Wait states (3 per request), then reset asserted mid-fetch
    begin_test(3);
    mem[0]  = 12'h20A;
    mem[1]  = 12'h20A;
    mem[10] = 12'h123;
    exp_rd(9'd0);
    exp_rd(9'd10);
    check("reset_bus_rd", 32'(bus_rd), 32'd0);
    check("reset_pc", 32'(pc), 32'd0);
    release_rst();
    cycles(9);
    check("ws_pc_before", 32'(pc), 32'd0);
    cycles(1);
    check("ws_ld_pc", 32'(pc), 32'd1);
    check("ws_ld_acc", 32'(acc), 32'h123);
    cycles(1);
    check("ws_fetch_pending", 32'(bus_rd), 32'd1);
    check("ws_fetch_addr", 32'(bus_addr), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_bus_rd", 32'(bus_rd), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_flag_z", 32'(flag_z), 32'd0);
    end_test("waitstate");

    // WAIT: early tick ignored, stall until tick, then HALT
    begin_test(0);
    mem[0] = 12'hF00;
    mem[1] = 12'hE00;
    exp_rd(9'd0);
    exp_rd(9'd1);
    release_rst();
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    cycles(15);
    check("wait_pc_stalled", 32'(pc), 32'd0);
    check("wait_not_stopped", 32'(stop), 32'd0);
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    cycles(1);
    check("wait_pc_after_tick", 32'(pc), 32'd1);
    wait_stop(50, n);
    check("wait_halt_cycles", 32'(n), 32'd2);
    end_test("wait");

    // CLR; DEC; BZ 0 (not taken); CLR; BZ 7 (taken); HALT
    begin_test(0);
    mem[0] = 12'hA00;
    mem[1] = 12'hC00;
    mem[2] = 12'h800;
    mem[3] = 12'hA00;
    mem[4] = 12'h807;
    mem[7] = 12'hE00;
    exp_rd(9'd0); exp_rd(9'd1); exp_rd(9'd2);
    exp_rd(9'd3); exp_rd(9'd4); exp_rd(9'd7);
    release_rst();
    cycles(9);
    check("dec_acc", 32'(acc), 32'hFFF);
    check("dec_flag_z", 32'(flag_z), 32'd0);
    check("bz_nt_pc", 32'(pc), 32'd3);
    cycles(5);
    check("bz_t_pc", 32'(pc), 32'd7);
    check("clr_acc", 32'(acc), 32'd0);
    check("clr_flag_z", 32'(flag_z), 32'd1);
    wait_stop(50, n);
    check("branch_halt_cycles", 32'(n), 32'd2);
    end_test("branch");

    // LD 10; ADD 11; ST 12; HALT with 5 + 7
    begin_test(0);
    mem[0]  = 12'h20A;
    mem[1]  = 12'h40B;
    mem[2]  = 12'h00C;
    mem[3]  = 12'hE00;
    mem[10] = 12'd5;
    mem[11] = 12'd7;
    exp_rd(9'd0); exp_rd(9'd10);
    exp_rd(9'd1); exp_rd(9'd11);
    exp_rd(9'd2); exp_wr(9'd12, 12'd12);
    exp_rd(9'd3);
    release_rst();
    wait_stop(100, n);
    check("prog_halt_cycles", 32'(n), 32'd14);
    check("prog_acc", 32'(acc), 32'd12);
    check("prog_stop", 32'(stop), 32'd1);
    check("prog_flag_z", 32'(flag_z), 32'd0);
    check("prog_pc", 32'(pc), 32'd3);
    cycles(5);
    check("halted_pc_frozen", 32'(pc), 32'd3);
    check("halted_stop_held", 32'(stop), 32'd1);
    end_test("prog");

    // ADD overflow: 0xFFF + 1 wraps to 0 and sets zero flag
    begin_test(0);
    mem[0]  = 12'h214;
    mem[1]  = 12'h415;
    mem[2]  = 12'h016;
    mem[3]  = 12'hE00;
    mem[20] = 12'hFFF;
    mem[21] = 12'd1;
    exp_rd(9'd0); exp_rd(9'd20);
    exp_rd(9'd1); exp_rd(9'd21);
    exp_rd(9'd2); exp_wr(9'd22, 12'd0);
    exp_rd(9'd3);
    release_rst();
    wait_stop(100, n);
    check("ovf_halt_cycles", 32'(n), 32'd14);
    check("ovf_acc", 32'(acc), 32'd0);
    check("ovf_flag_z", 32'(flag_z), 32'd1);
    end_test("ovf");

    // pc wrap: BZ 3 (not taken), CLR, BR 511, CLR at 511 -> pc 0, BZ 3 taken, HALT
    begin_test(0);
    mem[0]   = 12'h803;
    mem[1]   = 12'hA00;
    mem[2]   = 12'h7FF;
    mem[3]   = 12'hE00;
    mem[511] = 12'hA00;
    exp_rd(9'd0); exp_rd(9'd1); exp_rd(9'd2);
    exp_rd(9'd511); exp_rd(9'd0); exp_rd(9'd3);
    release_rst();
    cycles(8);
    check("br_pc", 32'(pc), 32'd511);
    cycles(3);
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_flag_z", 32'(flag_z), 32'd1);
    cycles(2);
    check("wrap_bz_pc", 32'(pc), 32'd3);
    wait_stop(50, n);
    check("wrap_halt_cycles", 32'(n), 32'd2);
    end_test("wrap");
`endif

    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
